ahbl_master_arbiter: RTL and testbench
======================================

Name: ahbl_master_arbiter

Overview:
- Two-requester AHB-Lite master front end that shares a single bus master port between two local requesters (e.g. a host CPU shim and a config sequencer) targeting register-style AHB-Lite slaves.
- Performs round-robin arbitration, issues one single-word NONSEQ transfer per grant, handles slave wait states and returns read data with a one-cycle ack.
- Sits between local control logic and the AHB-Lite interconnect; the interconnect decoder generates HSEL.

Parameters:
- TIMEOUT_CYCLES, 16, data-phase wait-state limit before error completion (used only with AHBL_ARB_TIMEOUT_EN); valid range 1..255.

Ports:
- HCLK  input  1  bus clock; one clock only.
- HRESET  input  1  asynchronous, active-high reset.
- req0 / req1  input  1  transfer request from requester 0 / 1.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  32  byte address, passed through unchanged.
- wdata0 / wdata1  input  32  write data.
- ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
- rdata  output  32  read data, valid in the ack cycle and held until the next read completes.
- err  output  1  error flag, valid in the ack cycle.
- busy  output  1  high whenever state != IDLE.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type.
- HSIZE  output  3  constant 3'b010 (word).
- HWRITE  output  1  AHB direction.
- HWDATA  output  32  AHB write data.
- HRDATA  input  32  AHB read data.
- HREADY  input  1  AHB ready.

Behaviour:
- Reset (async, HRESET=1), all outputs registered:
  - HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rdata=0, ack0=ack1=0, err=0, busy=0.
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: sample req0/req1.
  - If only one is high, grant it.
  - If both are high, grant the one != last_grant.
  - On grant: latch we/addr/wdata of the winner, update last_grant, go to ADDR.
- ADDR: drive HTRANS=2'b10 (NONSEQ), HADDR, HWRITE.
  - If HREADY=1: go to DATA, register HWDATA=latched wdata (writes only), and set HTRANS=2'b00 from the next cycle.
  - If HREADY=0: hold all address-phase signals.
- DATA: HTRANS=IDLE, HWDATA held.
  - If HREADY=1: capture HRDATA into rdata (reads only) and go to DONE.
  - If HREADY=0: wait indefinitely, unless the timeout feature is enabled.
- DONE: granted ack=1 for exactly this cycle, then go to IDLE.
  - Requester must hold req and attributes stable until it sees ack, and must drop req on the edge ending the ack cycle.
  - req is ignored in DONE.
- Latency with zero wait states: req sampled in cycle 0 → ADDR in cycle 1 → DATA in cycle 2 → ack in cycle 3. Each HREADY=0 cycle adds 1.
- Throughput: no pipelining; at most one transfer per 4 cycles; minimum one IDLE cycle between transfers.
- The loser of a tie stays pending and is granted in the next IDLE cycle. Strict alternation holds while both requesters stay asserted.
- A req deasserted before grant is simply not granted. A req deasserted mid-transfer does not abort the transfer; ack is still issued.
- Reset asserted mid-transfer: immediate return to the reset values; any in-flight transfer is abandoned with no ack.
- err=0 always, unless the timeout feature is enabled.

Optional Feature:
- Macro: AHBL_ARB_TIMEOUT_EN.
- When defined:
  - A wait counter increments each DATA cycle with HREADY=0.
  - When it reaches TIMEOUT_CYCLES: go to DONE with err=1, rdata=32'hDEAD_BEEF on reads, ack pulsed normally.
  - The counter clears on entry to DATA.
- When undefined: no counter logic; err tied to 0; DATA waits forever.

Test Plan:
- Write: req0=1, we0=1, addr0=32'h0000_0004, wdata0=32'h1234_5678, HREADY=1 → HTRANS=2'b10 with HADDR=4 in cycle 1; HWDATA=32'h1234_5678 in cycle 2; ack0 pulse in cycle 3; ack1 stays 0.
- Read with wait states: req1 read of addr 32'h8, HREADY low for 3 DATA cycles, HRDATA=32'hCAFE_0001 → ack1 in cycle 6; rdata=32'hCAFE_0001; err=0.
- Tie after reset: req0=req1=1 held, each dropped after its ack → requester 0 served first, then requester 1, with HADDR sequence addr0 then addr1.
- Sustained contention: both requesters re-request immediately after each ack for 6 transfers → grants alternate 0,1,0,1,0,1.
- Reset mid-DATA with HREADY=0: assert HRESET → next sample shows HTRANS=0, busy=0, no ack; a fresh req0 afterwards completes normally.
- AHBL_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and HREADY held 0 in DATA → ack0 with err=1 and rdata=32'hDEAD_BEEF after 4 wait cycles; FSM returns to IDLE.

Source files
------------

// File: rtl/ahbl_master_arbiter.sv
// Round-robin front end sharing one AHB-Lite master port between two requesters, one single-word NONSEQ per grant.
// Optional data-phase wait-state timeout enabled by defining AHBL_ARB_TIMEOUT_EN.
module ahbl_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gnt;
  logic [31:0] lat_wdata;
  logic        grant0, grant1;
  logic        timeout_hit;

  // last_grant resets to 1 so requester 0 wins the first tie
  assign grant0 = req0 & (~req1 | last_grant);
  assign grant1 = req1 & (~req0 | ~last_grant);
  assign HSIZE  = 3'b010;

`ifdef AHBL_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == DATA) && !HREADY && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wait_cnt <= 8'd0;
    end else if (state == ADDR && HREADY) begin
      wait_cnt <= 8'd0;
    end else if (state == DATA && !HREADY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant0 || grant1)         state_nxt = ADDR;
      ADDR: if (HREADY)                   state_nxt = DATA;
      DATA: if (HREADY || timeout_hit)    state_nxt = DONE;
      DONE:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      lat_wdata  <= 32'd0;
      HTRANS     <= HTRANS_IDLE;
      HADDR      <= 32'd0;
      HWRITE     <= 1'b0;
      HWDATA     <= 32'd0;
      rdata      <= 32'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            gnt        <= grant1;
            last_grant <= grant1;
            HTRANS     <= HTRANS_NONSEQ;
            HADDR      <= grant1 ? addr1  : addr0;
            HWRITE     <= grant1 ? we1    : we0;
            lat_wdata  <= grant1 ? wdata1 : wdata0;
          end
        end
        ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            if (HWRITE) HWDATA <= lat_wdata;
          end
        end
        DATA: begin
          // HWRITE still holds the direction of the transfer in flight
          if (HREADY) begin
            if (!HWRITE) rdata <= HRDATA;
            ack0 <= ~gnt;
            ack1 <= gnt;
          end else if (timeout_hit) begin
            if (!HWRITE) rdata <= 32'hDEAD_BEEF;
            err  <= 1'b1;
            ack0 <= ~gnt;
            ack1 <= gnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter: write, waited read, tie, contention, mid-transfer reset, optional timeout.
module tb_ahbl_master_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, busy;
  logic [31:0] rdata, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY;

  int tests = 0;
  int fails = 0;

  ahbl_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    HRDATA = 0; HREADY = 1'b1;
    step();
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr",  HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_rdata",  rdata, 32'd0);
    check("rst_flags",  {27'd0, ack0, ack1, err, busy, HWRITE}, 32'd0);
    check("hsize",      32'(HSIZE), 32'd2);
    HRESET = 1'b0;
    step();

    // Write from requester 0, no wait states
    req0 = 1; we0 = 1; addr0 = 32'h0000_0004; wdata0 = 32'h1234_5678;
    step();
    check("wr_c1_htrans", 32'(HTRANS), 32'h2);
    check("wr_c1_haddr",  HADDR, 32'h4);
    check("wr_c1_hwrite", 32'(HWRITE), 32'd1);
    check("wr_c1_busy",   32'(busy), 32'd1);
    step();
    check("wr_c2_htrans", 32'(HTRANS), 32'h0);
    check("wr_c2_hwdata", HWDATA, 32'h1234_5678);
    check("wr_c2_ack",    {30'd0, ack0, ack1}, 32'd0);
    step();
    check("wr_c3_acks",   {30'd0, ack0, ack1}, 32'b10);
    req0 = 0;
    step();
    check("wr_c4_acks",   {30'd0, ack0, ack1}, 32'd0);
    check("wr_c4_busy",   32'(busy), 32'd0);

    // Read from requester 1 with three data-phase wait states
    req1 = 1; we1 = 0; addr1 = 32'h8;
    step();
    check("rd_c1_haddr",  HADDR, 32'h8);
    check("rd_c1_hwrite", 32'(HWRITE), 32'd0);
    step();
    HREADY = 0;
    step();
    step();
    check("rd_c4_acks",   {30'd0, ack0, ack1}, 32'd0);
    check("rd_c4_busy",   32'(busy), 32'd1);
    step();
    HREADY = 1; HRDATA = 32'hCAFE_0001;
    step();
    check("rd_c6_acks",   {30'd0, ack0, ack1}, 32'b01);
    check("rd_c6_rdata",  rdata, 32'hCAFE_0001);
    check("rd_c6_err",    32'(err), 32'd0);
    req1 = 0; HRDATA = 0;
    step();
    check("rd_c7_rdata_hold", rdata, 32'hCAFE_0001);

    // Tie straight after reset: requester 0 first
    HRESET = 1;
    step();
    HRESET = 0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h100; addr1 = 32'h200;
    step();
    check("tie_first_haddr", HADDR, 32'h100);
    step();
    step();
    check("tie_first_ack", {30'd0, ack0, ack1}, 32'b10);
    req0 = 0;
    step();
    check("tie_idle_busy", 32'(busy), 32'd0);
    step();
    check("tie_second_haddr",  HADDR, 32'h200);
    check("tie_second_htrans", 32'(HTRANS), 32'h2);
    step();
    step();
    check("tie_second_ack", {30'd0, ack0, ack1}, 32'b01);
    req1 = 0;
    step();

    // Sustained contention: grants must alternate 0,1,0,1,0,1
    for (int k = 0; k < 6; k++) begin
      int lat;
      req0 = 1; req1 = 1;
      lat = 0;
      while (!(ack0 || ack1) && lat < 10) begin
        step();
        lat++;
      end
      check($sformatf("alt_winner_%0d", k), {30'd0, ack0, ack1}, (k % 2 == 0) ? 32'b10 : 32'b01);
      check($sformatf("alt_latency_%0d", k), 32'(lat), 32'd3);
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
      step();
    end
    req0 = 0; req1 = 0;
    step();

    // Reset during a stalled data phase
    req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hA5A5_0000;
    step();
    step();
    HREADY = 0;
    step();
    check("mid_busy_before", 32'(busy), 32'd1);
    HRESET = 1;
    #1;
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_busy",   32'(busy), 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    step();
    check("mid_rst_noack", {30'd0, ack0, ack1}, 32'd0);
    HRESET = 0; HREADY = 1; addr0 = 32'h44; wdata0 = 32'h0BAD_F00D;
    step();
    check("post_rst_haddr", HADDR, 32'h44);
    step();
    check("post_rst_hwdata", HWDATA, 32'h0BAD_F00D);
    step();
    check("post_rst_ack", {30'd0, ack0, ack1}, 32'b10);
    req0 = 0;
    step();

`ifdef AHBL_ARB_TIMEOUT_EN
    // Timeout after four stalled data cycles
    req0 = 1; we0 = 0; addr0 = 32'h50;
    step();
    check("tmo_c1_haddr", HADDR, 32'h50);
    step();
    HREADY = 0;
    step();
    step();
    step();
    check("tmo_c5_noack", {30'd0, ack0, ack1}, 32'd0);
    step();
    check("tmo_c6_ack",   {30'd0, ack0, ack1}, 32'b10);
    check("tmo_c6_err",   32'(err), 32'd1);
    check("tmo_c6_rdata", rdata, 32'hDEAD_BEEF);
    req0 = 0;
    step();
    check("tmo_c7_busy",  32'(busy), 32'd0);
    check("tmo_c7_err",   32'(err), 32'd0);
    HREADY = 1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
